maze_mem: RTL and testbench

- Maze storage stage directly downstream of the maze solver; it holds the wall bitmap and answers the solver's row/col/maze_oe/maze_we accesses with maze_in.
- Loaded row by row from a host over a valid/ready stream before solving starts.
- Records the cells the solver visits and counts them.
- After the solver asserts done, the visited bitmap can be read back row by row.

---
 rtl/maze_mem.sv | 139 +++++++++++++
 tb/tb_maze_mem.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mem.sv
// Maze wall/visited storage behind the solver: host row load, solver access, visited readback.
// Optional MAZE_MEM_STATS_EN builds the path_len counter and sticky wr_err flag.
module maze_mem #(
  parameter int maze_width = 6,
  parameter int cnt_width  = 2*maze_width+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [2**maze_width-1:0] load_data,
  output logic                  maze_ready,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  input  logic                  done,
  input  logic                  rd_req,
  input  logic [maze_width-1:0] rd_row,
  output logic [2**maze_width-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  load_restart,
  output logic [cnt_width-1:0]  path_len,
  output logic                  wr_err
);

  localparam int N = 2**maze_width;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DUMP
  } state_t;

  state_t                state;
  logic [maze_width-1:0] load_cnt;
  logic [N-1:0]          wall    [N];
  logic [N-1:0]          visited [N];

  logic load_fire;
  logic wall_bit;
  logic vis_bit;
  logic mark;
  logic clr;

  assign load_fire = load_valid && load_ready;
  assign wall_bit  = wall[row][col];
  assign vis_bit   = visited[row][col];
  assign mark      = (state == SERVE) && maze_we
                     && !wall_bit && !vis_bit;
  assign clr       = (state == DUMP) && load_restart;

  // Wall bitmap is never reset; the host always reloads it.
  always_ff @(posedge clk) begin
    if (load_fire)
      wall[load_cnt] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        visited[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < N; i++)
        visited[i] <= '0;
    end else if (mark) begin
      visited[row][col] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD;
      load_cnt   <= '0;
      load_ready <= 1'b1;
      maze_ready <= 1'b0;
      maze_in    <= 1'b0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        LOAD: begin
          if (load_fire) begin
            load_cnt <= load_cnt + 1'b1;
            if (load_cnt == maze_width'(N-1)) begin
              state      <= SERVE;
              load_ready <= 1'b0;
              maze_ready <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (maze_oe)
            maze_in <= wall_bit;
          if (done)
            state <= DUMP;
        end
        DUMP: begin
          if (load_restart) begin
            state      <= LOAD;
            load_cnt   <= '0;
            load_ready <= 1'b1;
            maze_ready <= 1'b0;
          end else if (rd_req) begin
            rd_data  <= visited[rd_row];
            rd_valid <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef MAZE_MEM_STATS_EN
  logic bad_wr;
  assign bad_wr = (state == SERVE) && maze_we && wall_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      path_len <= '0;
      wr_err   <= 1'b0;
    end else if (clr) begin
      path_len <= '0;
      wr_err   <= 1'b0;
    end else begin
      if (mark && path_len != cnt_width'(N*N))
        path_len <= path_len + 1'b1;
      if (bad_wr)
        wr_err <= 1'b1;
    end
  end
`else
  assign path_len = '0;
  assign wr_err   = 1'b0;
`endif

endmodule

// File: tb/tb_maze_mem.sv
// Self-checking bench for maze_mem: directed vector table plus randomized
// solver traffic against a cell-level reference model.
module tb_maze_mem;
  localparam int MW = 6;
  localparam int N  = 64;
  localparam int CW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [N-1:0]  load_data;
  logic          maze_ready;
  logic [MW-1:0] row, col;
  logic          maze_oe, maze_we;
  logic          maze_in;
  logic          done;
  logic          rd_req;
  logic [MW-1:0] rd_row;
  logic [N-1:0]  rd_data;
  logic          rd_valid;
  logic          load_restart;
  logic [CW-1:0] path_len;
  logic          wr_err;

  maze_mem dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .maze_ready(maze_ready),
    .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
    .done(done), .rd_req(rd_req), .rd_row(rd_row),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .load_restart(load_restart),
    .path_len(path_len), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [N-1:0] wall_m [N];
  bit           vis_m  [N][N];
  int           plen_m;
  bit           err_m;
  logic         mi_m;
  int           ld_idx;

  typedef struct {
    bit oe; bit we; int r; int c;
    bit mi; int pl; bit er;
  } vec_t;
  vec_t tbl [11];

  function automatic int st(int v);
`ifdef MAZE_MEM_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beats(int n, int mode);
    int sent;
    int guard;
    sent = 0;
    guard = 0;
    while (sent < n && guard < 2000) begin
      logic [N-1:0] d;
      bit acc;
      guard++;
      load_valid = ($urandom_range(0, 3) != 0);
      if (mode == 0) d = {1'b1, {(N-2){1'b0}}, 1'b1};
      else d = {$urandom, $urandom};
      load_data = d;
      acc = load_valid && load_ready;
      if (acc) wall_m[ld_idx] = d;
      tick;
      if (acc) begin
        sent++;
        ld_idx = (ld_idx + 1) % N;
      end
    end
    load_valid = 1'b0;
    if (sent < n) chk("load_timeout", sent, n);
  endtask

  task automatic clear_model;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        vis_m[i][j] = 0;
    plen_m = 0;
    err_m = 0;
  endtask

  function automatic logic [N-1:0] vis_row(int r);
    logic [N-1:0] v;
    for (int j = 0; j < N; j++) v[j] = vis_m[r][j];
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    load_valid = 0; load_data = '0;
    row = '0; col = '0; maze_oe = 0; maze_we = 0;
    done = 0; rd_req = 0; rd_row = '0; load_restart = 0;
    clear_model();
    mi_m = 0;
    ld_idx = 0;

    #12;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_maze_ready", maze_ready, 0);
    chk("rst_maze_in", maze_in, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_path_len", path_len, 0);
    chk("rst_wr_err", wr_err, 0);
    tick;
    rst = 1'b0;

    send_beats(63, 0);
    chk("ld63_load_ready", load_ready, 1);
    chk("ld63_maze_ready", maze_ready, 0);
    send_beats(1, 0);
    chk("ld64_load_ready", load_ready, 0);
    chk("ld64_maze_ready", maze_ready, 1);

    // Extra beat must be dropped; row 0 keeps its pattern.
    load_valid = 1; load_data = '1;
    tick;
    load_valid = 0;
    chk("extra_load_ready", load_ready, 0);

    tbl[0]  = '{1, 0, 0, 5,  0, 0, 0};
    tbl[1]  = '{1, 0, 5, 0,  1, 0, 0};
    tbl[2]  = '{0, 0, 5, 10, 1, 0, 0};
    tbl[3]  = '{1, 0, 5, 10, 0, 0, 0};
    tbl[4]  = '{0, 0, 5, 0,  0, 0, 0};
    tbl[5]  = '{0, 1, 5, 10, 0, 1, 0};
    tbl[6]  = '{0, 1, 5, 11, 0, 2, 0};
    tbl[7]  = '{0, 1, 5, 10, 0, 2, 0};
    tbl[8]  = '{0, 1, 5, 0,  0, 2, 1};
    tbl[9]  = '{1, 1, 5, 63, 1, 2, 1};
    tbl[10] = '{1, 1, 5, 11, 0, 2, 1};
    for (int i = 0; i < 11; i++) begin
      maze_oe = tbl[i].oe; maze_we = tbl[i].we;
      row = MW'(tbl[i].r); col = MW'(tbl[i].c);
      tick;
      chk($sformatf("vec%0d_maze_in", i), maze_in, tbl[i].mi);
      chk($sformatf("vec%0d_path_len", i), path_len, st(tbl[i].pl));
      chk($sformatf("vec%0d_wr_err", i), wr_err, st(int'(tbl[i].er)));
    end
    maze_oe = 0; maze_we = 0;
    mi_m = 0;

    done = 1;
    tick;
    done = 0;
    chk("done_rd_valid", rd_valid, 0);
    rd_req = 1; rd_row = 5;
    tick;
    chk("rb5_valid", rd_valid, 1);
    chk("rb5_data", rd_data, 64'h0000_0000_0000_0C00);
    rd_row = 6;
    tick;
    chk("rb6_valid", rd_valid, 1);
    chk("rb6_data", rd_data, 0);
    rd_req = 0;
    tick;
    chk("rb_pulse_end", rd_valid, 0);

    load_restart = 1; rd_req = 1; rd_row = 5;
    tick;
    load_restart = 0; rd_req = 0;
    chk("restart_rd_valid", rd_valid, 0);
    chk("restart_load_ready", load_ready, 1);
    chk("restart_maze_ready", maze_ready, 0);
    chk("restart_path_len", path_len, 0);
    chk("restart_wr_err", wr_err, 0);

    // Randomized walls and solver traffic on an 8x8 corner.
    ld_idx = 0;
    clear_model();
    send_beats(64, 1);
    chk("rnd_maze_ready", maze_ready, 1);
    for (int k = 0; k < 300; k++) begin
      int r, c;
      r = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      maze_oe = $urandom_range(0, 1);
      maze_we = $urandom_range(0, 1);
      done = (k == 299);
      row = MW'(r); col = MW'(c);
      if (maze_oe) mi_m = wall_m[r][c];
      if (maze_we) begin
        if (wall_m[r][c]) err_m = 1;
        else if (!vis_m[r][c]) begin
          vis_m[r][c] = 1;
          plen_m++;
        end
      end
      tick;
      chk("rnd_maze_in", maze_in, mi_m);
      chk("rnd_path_len", path_len, st(plen_m));
      chk("rnd_wr_err", wr_err, st(int'(err_m)));
    end
    done = 0;

    for (int k = 0; k < 5; k++) begin
      maze_oe = 1; maze_we = 1;
      row = MW'($urandom_range(0, 7));
      col = MW'($urandom_range(0, 7));
      tick;
      chk("dump_ign_maze_in", maze_in, mi_m);
      chk("dump_ign_path_len", path_len, st(plen_m));
      chk("dump_maze_ready", maze_ready, 1);
    end
    maze_oe = 0; maze_we = 0;

    for (int i = 0; i < 8; i++) begin
      rd_req = 1; rd_row = MW'(i);
      tick;
      chk("rnd_rb_valid", rd_valid, 1);
      chk($sformatf("rnd_rb_row%0d", i), rd_data, vis_row(i));
    end
    rd_req = 0;
    tick;
    chk("rnd_rb_end", rd_valid, 0);

    // Partial load then reset: a full 64 beats are needed again.
    load_restart = 1;
    tick;
    load_restart = 0;
    ld_idx = 0;
    send_beats(30, 1);
    rst = 1;
    #2;
    chk("midrst_load_ready", load_ready, 1);
    chk("midrst_maze_ready", maze_ready, 0);
    tick;
    rst = 0;
    ld_idx = 0;
    clear_model();
    send_beats(63, 0);
    chk("reld63_maze_ready", maze_ready, 0);
    chk("reld63_load_ready", load_ready, 1);
    send_beats(1, 0);
    chk("reld64_maze_ready", maze_ready, 1);
    done = 1;
    tick;
    done = 0;
    rd_req = 1; rd_row = 5;
    tick;
    rd_req = 0;
    chk("cleared_rb_valid", rd_valid, 1);
    chk("cleared_rb_data", rd_data, 0);
    chk("cleared_path_len", path_len, 0);

    rd_req = 1; rd_row = 3;
    tick;
    rd_req = 0;
    rst = 1;
    #1;
    chk("rst_kills_rd_valid", rd_valid, 0);
    tick;
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
